// File: rtl/irq_controller_n.sv
// irq_controller_n: 68k interrupt controller and 32-bit Wishbone slave; wb_* bus and IACK data/ack, irq_i asynchronous requests, int_ack_i CPU IACK cycle, ipl_o requested level
module irq_controller_n #(
  parameter int NUM_SRC = 16,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_BASE = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_reset_ni,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [5:0]         wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               int_ack_i,
  output logic [2:0]         ipl_o
);
  localparam logic [31:0] SRC_MASK = 32'((64'd1 << NUM_SRC) - 64'd1);
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [2:0] level_q [NUM_SRC];
  logic [7:0] vec_q [NUM_SRC];
  logic [31:0] s, s_prev_q, rise, pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
  logic [31:0] w1c, iack_clr, lane_mask, rd_data, wr_val, status, dat_q, dat_d;
  logic [2:0] ipl_q, win_lvl, cfg_lvl;
  logic [4:0] win_idx, iack_idx_q, last_idx_q, last_idx_d;
  logic [7:0] win_vec, iack_vec_q, cfg_vec;
  logic [5:0] cfg_idx;
  logic ack_q, ack_d, int_ack_q, iack_edge, iack_pend_q, iack_valid_q, spurious_q, spurious_d;
  logic bus_go, wr, cfg_hit;
  always_comb begin
    win_lvl = '0;
    win_idx = '0;
    win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pending_q[i] && enable_q[i] && level_q[i] > win_lvl) begin
        win_lvl = level_q[i];
        win_idx = 5'(i);
        win_vec = vec_q[i];
      end
  end
  always_comb begin
    cfg_idx = wb_adr_i - 6'd4;
    cfg_hit = wb_adr_i >= 6'd4 && {1'b0, cfg_idx} < 7'(NUM_SRC);
    cfg_lvl = '0;
    cfg_vec = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (6'(i) == cfg_idx) begin
        cfg_lvl = level_q[i];
        cfg_vec = vec_q[i];
      end
  end
  always_comb begin
    s = 32'(sync_q[SYNC_STAGES-1]);
    rise = s & ~s_prev_q;
    iack_edge = int_ack_i & ~int_ack_q;
    bus_go = wb_stb_i & ~ack_q & ~iack_pend_q & ~iack_edge;
    wr = bus_go & wb_we_i;
    status = {13'b0, ipl_q, 7'b0, spurious_q, 3'b0, last_idx_q};
    rd_data = wb_adr_i == 6'd0 ? pending_q :
              wb_adr_i == 6'd1 ? enable_q :
              wb_adr_i == 6'd2 ? mode_q :
              wb_adr_i == 6'd3 ? status :
              cfg_hit ? {16'b0, cfg_vec, 5'b0, cfg_lvl} : '0;
    lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wr_val = (rd_data & ~lane_mask) | (wb_dat_i & lane_mask);
    enable_d = wr && wb_adr_i == 6'd1 ? wr_val & SRC_MASK : enable_q;
    mode_d = wr && wb_adr_i == 6'd2 ? wr_val & SRC_MASK : mode_q;
    w1c = wr && wb_adr_i == 6'd0 ? wb_dat_i & lane_mask : '0;
    iack_clr = iack_pend_q && iack_valid_q ? 32'd1 << iack_idx_q : '0;
    // a new edge in the same cycle as a clear keeps the bit set
    pending_d = (mode_q & ((pending_q & ~(w1c | iack_clr)) | rise)) | (~mode_q & s);
    // IACK pre-empts the bus; a bus access waits for the next free ack slot
    ack_d = iack_pend_q | bus_go;
    dat_d = iack_pend_q ? (iack_valid_q ? {24'b0, iack_vec_q} : 32'd24) : bus_go ? rd_data : '0;
    spurious_d = iack_pend_q ? ~iack_valid_q : spurious_q;
    last_idx_d = iack_pend_q && iack_valid_q ? iack_idx_q : last_idx_q;
  end
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        level_q[i] <= '0;
        vec_q[i] <= 8'(VEC_BASE + i);
      end
      s_prev_q <= '0;
      pending_q <= '0;
      enable_q <= '0;
      mode_q <= '0;
      ipl_q <= '0;
      ack_q <= 1'b0;
      dat_q <= '0;
      int_ack_q <= 1'b0;
      iack_pend_q <= 1'b0;
      iack_valid_q <= 1'b0;
      iack_idx_q <= '0;
      iack_vec_q <= '0;
      spurious_q <= 1'b0;
      last_idx_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NUM_SRC; i++)
        if (wr && cfg_hit && 6'(i) == cfg_idx) begin
          level_q[i] <= wr_val[2:0];
          vec_q[i] <= wr_val[15:8];
        end
      s_prev_q <= s;
      pending_q <= pending_d;
      enable_q <= enable_d;
      mode_q <= mode_d;
      ipl_q <= int_ack_i ? ipl_q : win_lvl;
      ack_q <= ack_d;
      dat_q <= dat_d;
      int_ack_q <= int_ack_i;
      iack_pend_q <= iack_edge;
      if (iack_edge) begin
        iack_idx_q <= win_idx;
        iack_vec_q <= win_vec;
        iack_valid_q <= win_lvl != 3'd0;
      end
      spurious_q <= spurious_d;
      last_idx_q <= last_idx_d;
    end
  end
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign ipl_o = ipl_q;
endmodule

// File: tb/tb_irq_controller_n.sv
// tb_irq_controller_n: directed self-checking bench for irq_controller_n
module tb_irq_controller_n;
  logic clk, rst_n, stb, we, int_ack, ack;
  logic [5:0] adr;
  logic [3:0] sel;
  logic [31:0] din, dout, rd;
  logic [15:0] irq;
  logic [2:0] ipl;
  int total, bad, lat, nacks;
  irq_controller_n #(.NUM_SRC(16), .SYNC_STAGES(2), .VEC_BASE(64)) dut (
    .wb_clk_i(clk), .wb_reset_ni(rst_n), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(din), .wb_dat_o(dout), .wb_ack_o(ack), .irq_i(irq),
    .int_ack_i(int_ack), .ipl_o(ipl)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic xfer(input logic [5:0] a, input logic w, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
    logic got;
    got = 0;
    q = '0;
    adr = a; we = w; din = d; sel = s; stb = 1;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (ack) begin q = dout; got = 1; end
    end
    stb = 0; we = 0;
    if (!got) begin total++; bad++; $display("FAIL bus_timeout adr=%0d got=no_ack want=ack", a); end
  endtask
  task automatic do_iack(output logic [31:0] q, output int l, output int n);
    q = '0; l = -1; n = 0;
    int_ack = 1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (l < 0) begin q = dout; l = c; end
        n++;
      end
    end
  endtask
  task automatic test_reset;
    rst_n = 0; stb = 0; we = 0; adr = 0; sel = 0; din = 0; irq = 0; int_ack = 0;
    repeat (2) @(posedge clk); #1;
    total++; if (ipl !== 3'd0 || ack !== 1'b0 || dout !== 32'd0) begin bad++; $display("FAIL reset_outs got=%0d/%0d/%h want=0/0/0", ipl, ack, dout); end
    rst_n = 1;
    @(posedge clk); #1;
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_pending got=%h want=0", rd); end
    xfer(1, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_enable got=%h want=0", rd); end
    xfer(2, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_mode got=%h want=0", rd); end
    xfer(3, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_status got=%h want=0", rd); end
    xfer(4, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4000) begin bad++; $display("FAIL rst_cfg0 got=%h want=4000", rd); end
    xfer(7, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4300) begin bad++; $display("FAIL rst_cfg3 got=%h want=4300", rd); end
    xfer(19, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4f00) begin bad++; $display("FAIL rst_cfg15 got=%h want=4f00", rd); end
    xfer(20, 1, 32'hffffffff, 4'hf, rd);
    xfer(20, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped got=%h want=0", rd); end
  endtask
  task automatic pulse_irq2;
    @(posedge clk); #1 irq = 16'h0004;
    @(posedge clk); #1 irq = 16'h0000;
  endtask
  task automatic test_edge;
    xfer(6, 1, 32'h8005, 4'hf, rd);
    xfer(2, 1, 32'h4, 4'hf, rd);
    xfer(1, 1, 32'h4, 4'hf, rd);
    pulse_irq2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL edge_ipl_early got=%0d want=0", ipl); end
    @(posedge clk); #1;
    total++; if (ipl !== 3'd5) begin bad++; $display("FAIL edge_ipl got=%0d want=5", ipl); end
    do_iack(rd, lat, nacks);
    total++; if (rd !== 32'h80) begin bad++; $display("FAIL edge_iack_vec got=%h want=80", rd); end
    total++; if (lat !== 1) begin bad++; $display("FAIL edge_iack_lat got=%0d want=1", lat); end
    total++; if (nacks !== 1) begin bad++; $display("FAIL edge_iack_count got=%0d want=1", nacks); end
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL edge_pend_cleared got=%h want=0", rd); end
    total++; if (ipl !== 3'd5) begin bad++; $display("FAIL edge_ipl_frozen got=%0d want=5", ipl); end
    int_ack = 0;
    @(posedge clk); #1;
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL edge_ipl_release got=%0d want=0", ipl); end
    pulse_irq2;
    repeat (3) @(posedge clk); #1;
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4) begin bad++; $display("FAIL edge_pend_set got=%h want=4", rd); end
    xfer(0, 1, 32'h4, 4'b0010, rd);
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4) begin bad++; $display("FAIL w1c_wrong_lane got=%h want=4", rd); end
    xfer(0, 1, 32'h4, 4'hf, rd);
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_edge got=%h want=0", rd); end
  endtask
  task automatic test_priority;
    xfer(2, 1, 32'h0, 4'hf, rd);
    xfer(5, 1, 32'h1104, 4'hf, rd);
    xfer(10, 1, 32'h1604, 4'hf, rd);
    xfer(13, 1, 32'h1906, 4'hf, rd);
    xfer(1, 1, 32'h242, 4'hf, rd);
    irq = 16'h0242;
    repeat (4) @(posedge clk); #1;
    total++; if (ipl !== 3'd6) begin bad++; $display("FAIL prio_ipl6 got=%0d want=6", ipl); end
    do_iack(rd, lat, nacks);
    total++; if (rd !== 32'h19) begin bad++; $display("FAIL prio_vec9 got=%h want=19", rd); end
    int_ack = 0;
    irq = 16'h0042;
    repeat (5) @(posedge clk); #1;
    total++; if (ipl !== 3'd4) begin bad++; $display("FAIL prio_ipl4 got=%0d want=4", ipl); end
    do_iack(rd, lat, nacks);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL prio_tie_vec1 got=%h want=11", rd); end
    int_ack = 0;
    @(posedge clk); #1;
    xfer(3, 0, 0, 4'hf, rd); total++; if (rd !== 32'h40001) begin bad++; $display("FAIL prio_status got=%h want=40001", rd); end
  endtask
  task automatic test_level_w1c;
    xfer(0, 1, 32'h42, 4'hf, rd);
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'h42) begin bad++; $display("FAIL level_w1c got=%h want=42", rd); end
    irq = 16'h0000;
    repeat (3) @(posedge clk); #1;
    total++; if (ipl !== 3'd4) begin bad++; $display("FAIL level_drop_early got=%0d want=4", ipl); end
    @(posedge clk); #1;
    total++; if (ipl !== 3'd0) begin bad++; $display("FAIL level_drop got=%0d want=0", ipl); end
  endtask
  task automatic test_spurious;
    xfer(1, 1, 32'h0, 4'hf, rd);
    do_iack(rd, lat, nacks);
    total++; if (rd !== 32'd24) begin bad++; $display("FAIL spur_vec got=%0d want=24", rd); end
    int_ack = 0;
    @(posedge clk); #1;
    xfer(3, 0, 0, 4'hf, rd); total++; if (rd !== 32'h101) begin bad++; $display("FAIL spur_status got=%h want=101", rd); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] first, second;
    int n, c1, c2;
    n = 0; c1 = -1; c2 = -1; first = '0; second = '0;
    int_ack = 1; adr = 13; we = 0; sel = 4'hf; stb = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (n == 0) begin first = dout; c1 = c; end
        else if (n == 1) begin second = dout; c2 = c; stb = 0; end
        n++;
      end
    end
    stb = 0;
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_acks got=%0d want=2", n); end
    total++; if (first !== 32'd24 || c1 !== 1) begin bad++; $display("FAIL b2b_iack_first got=%h@%0d want=18@1", first, c1); end
    total++; if (second !== 32'h1906 || c2 !== 3) begin bad++; $display("FAIL b2b_bus_second got=%h@%0d want=1906@3", second, c2); end
    int_ack = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_iack;
    logic seen;
    seen = 0;
    xfer(2, 1, 32'h200, 4'hf, rd);
    xfer(1, 1, 32'h200, 4'hf, rd);
    irq = 16'h0200;
    repeat (5) @(posedge clk); #1;
    total++; if (ipl !== 3'd6) begin bad++; $display("FAIL mid_ipl got=%0d want=6", ipl); end
    int_ack = 1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total++; if (ipl !== 3'd0 || dout !== 32'd0) begin bad++; $display("FAIL mid_rst_outs got=%0d/%h want=0/0", ipl, dout); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ack) seen = 1;
    end
    int_ack = 0; irq = 0;
    #2 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_ack got=%0d want=0", seen); end
    xfer(1, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL mid_enable got=%h want=0", rd); end
    xfer(2, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL mid_mode got=%h want=0", rd); end
    xfer(0, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL mid_pending got=%h want=0", rd); end
    xfer(3, 0, 0, 4'hf, rd); total++; if (rd !== 32'd0) begin bad++; $display("FAIL mid_status got=%h want=0", rd); end
    xfer(13, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4900) begin bad++; $display("FAIL mid_cfg9 got=%h want=4900", rd); end
    xfer(6, 0, 0, 4'hf, rd); total++; if (rd !== 32'h4200) begin bad++; $display("FAIL mid_cfg2 got=%h want=4200", rd); end
  endtask
  initial begin
    total = 0; bad = 0;
    test_reset;
    test_edge;
    test_priority;
    test_level_w1c;
    test_spurious;
    test_back_to_back;
    test_reset_mid_iack;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
